// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug port, its register file and the core's RF port mux.
package rf_dbg_pkg;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;

    localparam logic CMD_DUMP = 1'b0;
    localparam logic CMD_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_ADDR,
        ST_D_WAIT,
        ST_D_OUT,
        ST_F_IN,
        ST_F_WR,
        ST_DONE
    } state_e;
endpackage

// File: rtl/regfile_debug_port.sv
// Debug master for the register file: dumps every register as a valid/ready stream, or fills
// registers from an input stream, raising busy so the core stays off the RF ports meanwhile.
module regfile_debug_port
    import rf_dbg_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter bit SKIP_X0  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic              cmd_op,
    output logic              cmd_ready,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] rf_rr,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0] rf_wd
);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FILL_START = ADDR_W'(SKIP_X0 ? 1 : 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] rf_wr_q, rf_wr_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic              at_last;
    logic              in_dump;

    assign at_last = (idx_q == LAST_IDX);
    assign in_dump = (state_q == ST_D_ADDR) || (state_q == ST_D_WAIT) || (state_q == ST_D_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            out_data_q <= '0;
            rf_wr_q    <= '0;
            rf_wd_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_data_q <= out_data_d;
            rf_wr_q    <= rf_wr_d;
            rf_wd_q    <= rf_wd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_data_d = out_data_q;
        rf_wr_d    = rf_wr_q;
        rf_wd_d    = rf_wd_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == CMD_FILL) begin
                        idx_d   = FILL_START;
                        state_d = ST_F_IN;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_D_ADDR;
                    end
                end
            end
            ST_D_ADDR: state_d = ST_D_WAIT;
            ST_D_WAIT: begin
                // Read data is valid here because rf_rr has been held at idx since D_ADDR.
                out_data_d = rf_rd;
                state_d    = ST_D_OUT;
            end
            ST_D_OUT: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_D_ADDR;
                    end
                end
            end
            ST_F_IN: begin
                if (in_valid) begin
                    rf_wr_d = idx_q;
                    rf_wd_d = in_data;
                    state_d = ST_F_WR;
                end
            end
            ST_F_WR: begin
                if (at_last) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_F_IN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign out_valid = (state_q == ST_D_OUT);
    assign out_idx   = out_valid ? idx_q : '0;
    assign out_data  = out_data_q;
    assign out_last  = out_valid && at_last;
    assign in_ready  = (state_q == ST_F_IN);
    assign rf_rr     = in_dump ? idx_q : '0;
    // Write address/data are registered one cycle ahead so they are stable for the whole rf_we pulse.
    assign rf_we     = (state_q == ST_F_WR);
    assign rf_wr     = rf_wr_q;
    assign rf_wd     = rf_wd_q;
endmodule

// File: tb/tb_regfile_debug_port.sv
// Randomized bench for regfile_debug_port with a behavioural register file and expected-contents model.
module tb_regfile_debug_port;
    import rf_dbg_pkg::*;

    localparam int NREG = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_op = 1'b0;
    logic        cmd_ready, busy, done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        out_last;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  rf_rr;
    logic [31:0] rf_rd;
    logic        rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;

    // bench-side register file and its preset/clear hooks
    logic [31:0] rf_mem [NREG];
    logic        rf_clr = 1'b0;
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    // expected architectural contents
    logic [31:0] ref_regs [NREG];

    int vec_cnt = 0;
    int err_cnt = 0;
    int wr_cnt = 0;
    int we2_cnt = 0;
    int done_cnt = 0;
    logic we_prev = 1'b0;

    always #5 clk = ~clk;

    regfile_debug_port dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .out_last  (out_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rf_rr     (rf_rr),
        .rf_rd     (rf_rd),
        .rf_we     (rf_we),
        .rf_wr     (rf_wr),
        .rf_wd     (rf_wd)
    );

    always @(posedge clk) begin
        for (int k = 0; k < NREG; k++) begin
            if (rf_clr) rf_mem[k] <= '0;
        end
        if (pre_en) rf_mem[pre_addr] <= pre_data;
        if (rf_we) rf_mem[rf_wr] <= rf_wd;
        rf_rd <= rf_mem[rf_rr];
    end

    always @(posedge clk) begin
        if (rf_we) wr_cnt <= wr_cnt + 1;
        if (rf_we && we_prev) we2_cnt <= we2_cnt + 1;
        we_prev <= rf_we;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rf_clr = 1'b1;
        repeat (3) step();
        rf_clr = 1'b0;
        for (int k = 0; k < NREG; k++) ref_regs[k] = '0;
        vec_cnt++;
        if ({cmd_ready, busy, done, out_valid, in_ready, rf_we, out_last} !== 7'b1000000) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b want 1000000", {cmd_ready, busy, done, out_valid, in_ready, rf_we, out_last});
        end
        rst = 1'b0;
        step();
        vec_cnt++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rf_rr !== 5'd0 || rf_wr !== 5'd0 || rf_wd !== 32'd0 || out_data !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_idle: cmd_ready=%b busy=%b rr=%0d wr=%0d wd=%h od=%h want 1 0 0 0 0 0",
                     cmd_ready, busy, rf_rr, rf_wr, rf_wd, out_data);
        end
        $display("reset: applied, cmd_ready=%b busy=%b", cmd_ready, busy);
    endtask

    task automatic preset_reg(input int a, input logic [31:0] d);
        pre_en = 1'b1;
        pre_addr = 5'(a);
        pre_data = d;
        step();
        pre_en = 1'b0;
        ref_regs[a] = d;
    endtask

    task automatic check_rf_contents(input string tag);
        for (int k = 0; k < NREG; k++) begin
            vec_cnt++;
            if (rf_mem[k] !== ref_regs[k]) begin
                err_cnt++;
                $display("FAIL %s_rf_x%0d: got %h want %h", tag, k, rf_mem[k], ref_regs[k]);
            end
        end
    endtask

    // Issues a DUMP and consumes the stream, checking every presented word against ref_regs.
    task automatic run_dump(input string tag, input int stall_idx, input int stall_len,
                            input bit rand_rdy, input int exp_last_edge, input int poke_cyc);
        int nxt = 0;
        int cyc = 0;
        int last_edge = -1;
        int stall_left = stall_len;
        int done0 = done_cnt;
        bit rdy;
        cmd_op = CMD_DUMP;
        cmd_valid = 1'b1;
        out_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        while (nxt < NREG && cyc < 3000) begin
            vec_cnt++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL %s_busy: cyc=%0d busy=%b cmd_ready=%b want 1 0", tag, cyc, busy, cmd_ready);
            end
            if (out_valid === 1'b1) begin
                vec_cnt++;
                if (out_idx !== 5'(nxt) || out_data !== ref_regs[nxt] || out_last !== (nxt == NREG - 1)) begin
                    err_cnt++;
                    $display("FAIL %s_word: idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                             tag, out_idx, out_data, out_last, nxt, ref_regs[nxt], (nxt == NREG - 1));
                end
                if (nxt == stall_idx && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else begin
                    rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (rdy) begin
                    $display("%s: word idx=%0d data=%h last=%b", tag, out_idx, out_data, out_last);
                    if (nxt == NREG - 1) last_edge = cyc + 1;
                    nxt++;
                end
                out_ready = rdy;
            end else begin
                vec_cnt++;
                if (out_last !== 1'b0 || done !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL %s_idle_out: last=%b done=%b want 0 0", tag, out_last, done);
                end
                out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            cmd_op = CMD_FILL;
            cmd_valid = (poke_cyc >= 0 && cyc >= poke_cyc && cyc < poke_cyc + 3);
            step();
            cyc++;
        end
        cmd_valid = 1'b0;
        cmd_op = CMD_DUMP;
        vec_cnt++;
        if (nxt != NREG) begin
            err_cnt++;
            $display("FAIL %s_timeout: got %0d words want %0d", tag, nxt, NREG);
        end
        if (exp_last_edge > 0) begin
            vec_cnt++;
            if (last_edge != exp_last_edge) begin
                err_cnt++;
                $display("FAIL %s_latency: got %0d cycles want %0d", tag, last_edge, exp_last_edge);
            end
        end
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_done: done=%b busy=%b want 1 1", tag, done, busy);
        end
        step();
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || (done_cnt - done0) != 1) begin
            err_cnt++;
            $display("FAIL %s_end: done=%b busy=%b cmd_ready=%b pulses=%0d want 0 0 1 1",
                     tag, done, busy, cmd_ready, done_cnt - done0);
        end
        step();
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_not_requeued: busy=%b want 0", tag, busy);
        end
    endtask

    // Issues a FILL of x1..x31; stop_after>0 resets the DUT in the write cycle of that word.
    task automatic run_fill(input string tag, input int gap_max, input int stop_after,
                            input bit rand_data, input logic [31:0] base);
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int t;
        logic [31:0] d;
        cmd_op = CMD_FILL;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            d = rand_data ? $urandom : base + 32'(i);
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) step();
            in_valid = 1'b1;
            in_data = d;
            t = 0;
            while (in_ready !== 1'b1 && t < 20) begin
                step();
                t++;
            end
            if (t >= 20) begin
                err_cnt++;
                vec_cnt++;
                $display("FAIL %s_in_timeout: word %0d in_ready=%b want 1", tag, i, in_ready);
                in_valid = 1'b0;
                return;
            end
            step();
            in_valid = 1'b0;
            ref_regs[i] = d;
            vec_cnt++;
            if (rf_we !== 1'b1 || rf_wr !== 5'(i) || rf_wd !== d) begin
                err_cnt++;
                $display("FAIL %s_write: we=%b wr=%0d wd=%h want 1 %0d %h", tag, rf_we, rf_wr, rf_wd, i, d);
            end
            $display("%s: write x%0d=%h", tag, rf_wr, rf_wd);
            if (i == stop_after) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                vec_cnt++;
                if ({rf_we, busy, cmd_ready, in_ready, done, out_valid} !== 6'b001000) begin
                    err_cnt++;
                    $display("FAIL %s_abort: we,busy,rdy,in_rdy,done,ov=%b want 001000",
                             tag, {rf_we, busy, cmd_ready, in_ready, done, out_valid});
                end
                vec_cnt++;
                if ((wr_cnt - w0) != stop_after) begin
                    err_cnt++;
                    $display("FAIL %s_abort_writes: got %0d want %0d", tag, wr_cnt - w0, stop_after);
                end
                check_rf_contents(tag);
                return;
            end
        end
        step();
        vec_cnt++;
        if (done !== 1'b1 || rf_we !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_done: done=%b we=%b want 1 0", tag, done, rf_we);
        end
        step();
        vec_cnt++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || (done_cnt - d0) != 1) begin
            err_cnt++;
            $display("FAIL %s_end: busy=%b cmd_ready=%b pulses=%0d want 0 1 1", tag, busy, cmd_ready, done_cnt - d0);
        end
        vec_cnt++;
        if ((wr_cnt - w0) != NREG - 1 || we2_cnt != 0) begin
            err_cnt++;
            $display("FAIL %s_pulses: writes=%0d wide=%0d want %0d 0", tag, wr_cnt - w0, we2_cnt, NREG - 1);
        end
        check_rf_contents(tag);
    endtask

    task automatic test_dump_basic();
        preset_reg(5, 32'd4);
        run_dump("dump_basic", -1, 0, 1'b0, 96, -1);
    endtask

    task automatic test_dump_stall();
        run_dump("dump_stall", 3, 5, 1'b0, 101, -1);
    endtask

    task automatic test_fill();
        run_fill("fill_a0", 0, 0, 1'b0, 32'hA0);
        run_dump("dump_after_fill", -1, 0, 1'b0, 96, -1);
    endtask

    task automatic test_fill_gaps();
        run_fill("fill_gaps", 3, 0, 1'b1, 32'h0);
        run_dump("dump_rand_ready", -1, 0, 1'b1, -1, -1);
    endtask

    task automatic test_reset_abort();
        run_fill("fill_abort", 2, 10, 1'b0, 32'h5500);
        run_dump("dump_after_abort", -1, 0, 1'b0, 96, -1);
    endtask

    task automatic test_cmd_ignored();
        run_dump("dump_cmd_poke", -1, 0, 1'b0, 96, 40);
    endtask

    initial begin
        test_reset();
        test_dump_basic();
        test_dump_stall();
        test_fill();
        test_fill_gaps();
        test_reset_abort();
        test_cmd_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
